// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP                = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS_DEFAULT = 32'd128;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the instruction memory and decode.
// master: the fetch sequencer side; slave: the memory/decode/control side.
interface fetch_sequencer_if;

  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] IMemInstruction;
  logic [31:0] IMemAddress;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic        Valid;
  logic        Halted;
  logic        AlignErr;
  logic [31:0] FetchCount;

  modport master (
    input  Stall, Redirect, RedirectPC, IMemInstruction,
    output IMemAddress, InstrOut, PCPlus4Out, Valid, Halted, AlignErr, FetchCount
  );

  modport slave (
    output Stall, Redirect, RedirectPC, IMemInstruction,
    input  IMemAddress, InstrOut, PCPlus4Out, Valid, Halted, AlignErr, FetchCount
  );

endinterface

// File: rtl/fetch_sequencer_pc_register.sv
// Program-counter flop: synchronous reset, then load, then enable.
module pc_register #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] q_r;

  // PC update with reset > load > enable priority
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else if (load) begin
      q_r <= load_val;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the instruction
// memory and registers the fetched word for decode, with stall, redirect
// (one-bubble squash) and out-of-range halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input logic             Clk,
  input logic             Reset,
  fetch_sequencer_if.master bus
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 32'd4);

  fetch_state_e state_r;
  fetch_state_e next_state_s;

  logic [31:0] pc_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] redirect_pc_s;
  logic        out_of_range_s;
  logic        halt_s;
  logic        advance_s;

  logic [31:0] instr_r;
  logic [31:0] pc_plus4_r;
  logic        valid_r;
  logic        align_err_r;
  logic [31:0] fetch_count_r;

  assign pc_plus4_s     = pc_s + 32'd4;
  assign redirect_pc_s  = {bus.RedirectPC[31:2], 2'b00};
  assign out_of_range_s = (pc_s >= PC_LIMIT);

  pc_register #(
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk      (Clk),
    .rst      (Reset),
    .load     (bus.Redirect),
    .load_val (redirect_pc_s),
    .en       (advance_s),
    .d        (pc_plus4_s),
    .q        (pc_s)
  );

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state plus halt/advance strobes; redirect beats halt beats stall
  always_comb begin
    next_state_s = state_r;
    halt_s       = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.Redirect) begin
          next_state_s = RUN;
        end else if (out_of_range_s) begin
          next_state_s = HALTED;
          halt_s       = 1'b1;
        end else if (!bus.Stall) begin
          advance_s = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      HALTED: begin
        if (bus.Redirect) begin
          next_state_s = RUN;
        end else begin
          next_state_s = HALTED;
        end
      end
      default: begin
        next_state_s = RUN;
      end
    endcase
  end

  // IF/ID output register, alignment pulse and delivery counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      instr_r       <= NOP;
      pc_plus4_r    <= 32'h0000_0000;
      valid_r       <= 1'b0;
      align_err_r   <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
    end else if (bus.Redirect) begin
      instr_r     <= NOP;
      valid_r     <= 1'b0;
      align_err_r <= |bus.RedirectPC[1:0];
    end else begin
      align_err_r <= 1'b0;
      if (halt_s) begin
        instr_r <= NOP;
        valid_r <= 1'b0;
      end else if (advance_s) begin
        instr_r       <= bus.IMemInstruction;
        pc_plus4_r    <= pc_plus4_s;
        valid_r       <= 1'b1;
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        instr_r <= instr_r;
        valid_r <= valid_r;
      end
    end
  end

  assign bus.IMemAddress = pc_s;
  assign bus.InstrOut    = instr_r;
  assign bus.PCPlus4Out  = pc_plus4_r;
  assign bus.Valid       = valid_r;
  assign bus.Halted      = (state_r == HALTED);
  assign bus.AlignErr    = align_err_r;
  assign bus.FetchCount  = fetch_count_r;

endmodule
